// File: rtl/run_controller.sv
// Bring-up run sequencer: holds the core in reset for a programmed time, then
// watches the zero flag for a stable halt (PASS) or a cycle timeout (FAIL).
module run_controller #(
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned RESET_CYCLES   = 20,
  parameter int unsigned TIMEOUT_CYCLES = 300,
  parameter int unsigned HALT_STABLE    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic             zero_in,
  output logic             core_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALT_LAST    = CNT_W'(HALT_STABLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RESET_HOLD = 3'd1,
    ST_RUN        = 3'd2,
    ST_PASS       = 3'd3,
    ST_FAIL       = 3'd4
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] hold_q;
  logic [CNT_W-1:0] halt_q;
  logic [CNT_W-1:0] cycle_q;
  logic             core_reset_q;
  logic             running_q;
  logic             done_q;
  logic             timeout_q;

  logic pass_hit_c;
  logic tout_hit_c;

  // PASS takes priority over timeout when both land on the same edge.
  assign pass_hit_c = zero_in && (halt_q == HALT_LAST);
  assign tout_hit_c = (cycle_q == TIMEOUT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      halt_q       <= '0;
      cycle_q      <= '0;
      core_reset_q <= 1'b1;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RESET_HOLD;
            hold_q  <= '0;
            cycle_q <= '0;
          end
        end

        ST_RESET_HOLD: begin
          hold_q <= hold_q + CNT_ONE;
          if (hold_q == HOLD_LAST) begin
            state_q      <= ST_RUN;
            cycle_q      <= '0;
            halt_q       <= '0;
            core_reset_q <= 1'b0;
            running_q    <= 1'b1;
          end
        end

        ST_RUN: begin
          cycle_q <= cycle_q + CNT_ONE;
          halt_q  <= zero_in ? (halt_q + CNT_ONE) : '0;
          if (pass_hit_c) begin
            state_q   <= ST_PASS;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (tout_hit_c) begin
            state_q   <= ST_FAIL;
            running_q <= 1'b0;
            timeout_q <= 1'b1;
          end
        end

        ST_PASS, ST_FAIL: begin
          // Re-run restarts the full reset sequence; start beats clear.
          if (start) begin
            state_q      <= ST_RESET_HOLD;
            hold_q       <= '0;
            cycle_q      <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
          end else if (clear) begin
            state_q      <= ST_IDLE;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
          end
        end

        default: begin
          state_q      <= ST_IDLE;
          core_reset_q <= 1'b1;
          running_q    <= 1'b0;
          done_q       <= 1'b0;
          timeout_q    <= 1'b0;
        end
      endcase
    end
  end

  assign core_reset  = core_reset_q;
  assign running     = running_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: reset/start, halt pass, glitchy halt,
// timeout, pass/timeout tie, async reset mid-run and start+clear priority.
module tb_run_controller;

  localparam int unsigned CNT_W = 8;

  logic             clock;
  logic             reset;
  logic             start;
  logic             clear;
  logic             zero_in;
  logic             core_reset;
  logic             running;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;

  int tests    = 0;
  int failures = 0;

  run_controller #(
    .CNT_W         (8),
    .RESET_CYCLES  (4),
    .TIMEOUT_CYCLES(20),
    .HALT_STABLE   (3)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .clear      (clear),
    .zero_in    (zero_in),
    .core_reset (core_reset),
    .running    (running),
    .done       (done),
    .timeout    (timeout),
    .cycle_count(cycle_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One-cycle start pulse, then walk through the 4-cycle reset hold into RUN cycle 0.
  task automatic launch(input logic with_clear);
    start = 1'b1;
    clear = with_clear;
    ticks(1);
    start = 1'b0;
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("hold_core_reset", 32'(core_reset), 32'd1);
      check("hold_running", 32'(running), 32'd0);
      ticks(1);
    end
    check("run_entry_running", 32'(running), 32'd1);
    check("run_entry_core_reset", 32'(core_reset), 32'd0);
    check("run_entry_count", 32'(cycle_count), 32'd0);
  endtask

  logic pat [6];

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    clear   = 1'b0;
    zero_in = 1'b0;
    ticks(2);
    reset = 1'b0;
    ticks(5);
    check("idle_core_reset", 32'(core_reset), 32'd1);
    check("idle_running", 32'(running), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_timeout", 32'(timeout), 32'd0);
    check("idle_count", 32'(cycle_count), 32'd0);

    // Halt pass: zero_in high from RUN cycle 5
    launch(1'b0);
    ticks(5);
    check("hp_count5", 32'(cycle_count), 32'd5);
    zero_in = 1'b1;
    ticks(1);
    check("hp_done_1st", 32'(done), 32'd0);
    ticks(1);
    check("hp_done_2nd", 32'(done), 32'd0);
    ticks(1);
    check("hp_done", 32'(done), 32'd1);
    check("hp_count", 32'(cycle_count), 32'd8);
    check("hp_running", 32'(running), 32'd0);
    check("hp_core_reset", 32'(core_reset), 32'd0);
    for (int i = 0; i < 10; i++) begin
      zero_in = i[0];
      ticks(1);
    end
    check("hp_frozen_count", 32'(cycle_count), 32'd8);
    check("hp_sticky_done", 32'(done), 32'd1);

    // Glitchy halt: 1,1,0,1,1,1 starting at RUN cycle 2
    zero_in = 1'b0;
    launch(1'b0);
    check("gl_done_cleared", 32'(done), 32'd0);
    ticks(2);
    pat[0] = 1'b1; pat[1] = 1'b1; pat[2] = 1'b0;
    pat[3] = 1'b1; pat[4] = 1'b1; pat[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      zero_in = pat[i];
      ticks(1);
      if (i < 5) check("gl_early_done", 32'(done), 32'd0);
    end
    check("gl_done", 32'(done), 32'd1);
    check("gl_count", 32'(cycle_count), 32'd8);

    // Timeout with zero_in low throughout
    zero_in = 1'b0;
    launch(1'b0);
    ticks(19);
    check("to_count19", 32'(cycle_count), 32'd19);
    check("to_not_yet", 32'(timeout), 32'd0);
    check("to_running19", 32'(running), 32'd1);
    ticks(1);
    check("to_timeout", 32'(timeout), 32'd1);
    check("to_count", 32'(cycle_count), 32'd20);
    check("to_done", 32'(done), 32'd0);
    check("to_running", 32'(running), 32'd0);
    clear = 1'b1;
    ticks(1);
    clear = 1'b0;
    check("clr_core_reset", 32'(core_reset), 32'd1);
    check("clr_timeout", 32'(timeout), 32'd0);
    ticks(2);
    check("clr_stays_idle", 32'(running), 32'd0);

    // Tie: third consecutive 1 on the cycle_count==19 edge
    launch(1'b0);
    ticks(17);
    zero_in = 1'b1;
    ticks(2);
    check("tie_count19", 32'(cycle_count), 32'd19);
    check("tie_done_early", 32'(done), 32'd0);
    ticks(1);
    check("tie_done", 32'(done), 32'd1);
    check("tie_timeout", 32'(timeout), 32'd0);
    check("tie_count", 32'(cycle_count), 32'd20);

    // start+clear together from PASS: start wins
    zero_in = 1'b0;
    launch(1'b1);
    check("sc_done_cleared", 32'(done), 32'd0);

    // Async reset between edges at RUN cycle 10
    ticks(10);
    check("ar_count10", 32'(cycle_count), 32'd10);
    check("ar_running_pre", 32'(running), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_core_reset", 32'(core_reset), 32'd1);
    check("ar_running", 32'(running), 32'd0);
    check("ar_count", 32'(cycle_count), 32'd0);
    ticks(1);
    reset = 1'b0;
    ticks(4);
    check("ar_no_restart_rst", 32'(core_reset), 32'd1);
    check("ar_no_restart_run", 32'(running), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
- Parametrised, synthesizable run controller for processor bring-up, replacing fixed-delay reset and finish timing with a hardware sequencer.
- Holds the core in reset for a programmable number of cycles, then releases it.
- Counts execution cycles and declares PASS when the core's zero flag is held stable for a programmable number of cycles, or FAIL on timeout.
- Sits between the top-level clock/reset and the processor's reset input; its status outputs drive benches and board LEDs.

Parameters:
- CNT_W, 16, width of the cycle counter and internal counters.
- RESET_CYCLES, 20, number of cycles core_reset is held high after start; legal range 1..2^CNT_W-1.
- TIMEOUT_CYCLES, 300, maximum RUN cycles before FAIL; legal range 1..2^CNT_W-1.
- HALT_STABLE, 4, consecutive RUN cycles zero_in must be 1 to declare PASS; legal range 1..2^CNT_W-1.

Ports:
- clock, input, 1, single system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high; forces IDLE immediately.
- start, input, 1, level sampled each cycle; launches a run from IDLE, PASS or FAIL.
- clear, input, 1, returns PASS or FAIL to IDLE; ignored in other states.
- zero_in, input, 1, zero flag from the processor.
- core_reset, output, 1, reset to the processor; high in IDLE and RESET_HOLD.
- running, output, 1, high only in RUN.
- done, output, 1, high only in PASS.
- timeout, output, 1, high only in FAIL.
- cycle_count, output, CNT_W, number of RUN cycles elapsed; frozen in PASS and FAIL.

Behaviour:
- States: IDLE, RESET_HOLD, RUN, PASS, FAIL. All outputs are registered or decoded from the state register only, with no combinational path from inputs to outputs.
- Reset (asynchronous, any state): state=IDLE, core_reset=1, running=0, done=0, timeout=0, cycle_count=0, hold counter=0, halt counter=0.
- IDLE:
  - start=1 at edge k → RESET_HOLD from edge k; hold counter=0; cycle_count=0.
  - Otherwise stay in IDLE.
- RESET_HOLD:
  - core_reset=1.
  - Hold counter increments each edge.
  - At the edge where hold counter == RESET_CYCLES-1, go to RUN. core_reset is therefore high for exactly RESET_CYCLES cycles after the start edge.
  - On RUN entry: cycle_count=0 and halt counter=0.
  - start and clear are ignored.
- RUN:
  - core_reset=0 and running=1.
  - cycle_count increments by 1 every edge.
  - Halt counter increments when zero_in=1 and resets to 0 when zero_in=0.
  - PASS condition: zero_in=1 and halt counter == HALT_STABLE-1 at an edge → PASS.
  - FAIL condition: cycle_count == TIMEOUT_CYCLES-1 at an edge and the PASS condition is not met → FAIL, with cycle_count=TIMEOUT_CYCLES.
  - Simultaneous PASS and FAIL conditions at the same edge: PASS wins.
  - cycle_count still increments on the transition edge in both cases.
  - start and clear are ignored.
- PASS / FAIL:
  - Sticky. core_reset=0, so the core is left running to allow inspection. cycle_count is frozen.
  - start=1 → RESET_HOLD (re-run, same sequencing as from IDLE).
  - clear=1 with start=0 → IDLE.
  - start and clear both 1 → start wins.
- cycle_count never wraps: its maximum is TIMEOUT_CYCLES, which is below 2^CNT_W by parameter constraint.
- Reset asserted mid-RUN: core_reset goes high asynchronously and all status clears. After reset deasserts, the block waits in IDLE for start; there is no auto-restart.
- zero_in is sampled only in RUN. Its value during RESET_HOLD, PASS, FAIL and IDLE has no effect.

Test Plan:
All scenarios use RESET_CYCLES=4, TIMEOUT_CYCLES=20, HALT_STABLE=3, CNT_W=8.
- Reset/start: assert reset, release, hold start=0 for 5 cycles → IDLE, core_reset=1, all flags 0. Pulse start for 1 cycle → core_reset high for exactly 4 more edges, then running=1 and core_reset=0.
- Halt pass: in RUN, drive zero_in=1 from RUN cycle 5 onward → done=1 after the 3rd consecutive sampled 1, cycle_count=8, running=0. cycle_count stays at 8 for 10 further cycles.
- Glitchy halt: zero_in pattern 1,1,0,1,1,1 starting at RUN cycle 2 → the pattern's final 1 (6th RUN edge of the pattern) triggers PASS, not the second 1.
- Timeout: zero_in=0 throughout → timeout=1 exactly 20 RUN cycles after entry, cycle_count=20, done=0. Apply clear → IDLE, core_reset=1, timeout=0.
- Tie: zero_in=1 starting so that the 3rd consecutive 1 lands on the edge with cycle_count=19 → done=1, timeout=0.
- Async reset mid-run and restart: assert reset between clock edges at RUN cycle 10 → core_reset=1 and running=0 before the next edge. Separately, from PASS, assert start and clear together → RESET_HOLD, core_reset=1 for 4 cycles.
